// File: rtl/qcm_pkg.sv
// -----------------------------------------------------------------------------
// qcm_pkg
// Shared types for the tableau pipeline: single-qubit Pauli literal encoding,
// the nominal tableau row layout and the row-buffer state encoding.
// -----------------------------------------------------------------------------
package qcm_pkg;

    // Two-bit Pauli literal encoding used on every literals bus.
    typedef enum logic [1:0] {
        LIT_I = 2'b00,
        LIT_Z = 2'b01,
        LIT_X = 2'b10,
        LIT_Y = 2'b11
    } literal_e;

    // Nominal qubit count of the pipeline; row_t is laid out for it.
    localparam int unsigned QCM_NUM_QUBIT = 3;

    // One tableau row: per-qubit literals (qubit q at [q]) plus the phase bit.
    // Packed so that {literals, phase} maps straight onto a flat row word.
    typedef struct packed {
        logic [QCM_NUM_QUBIT-1:0][1:0] literals;
        logic                          phase;
    } row_t;

    // Row buffer sequencing.
    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_WAIT_GP = 2'd1,
        ST_READOUT = 2'd2
    } buf_state_e;

endpackage

// File: rtl/tableau_row_mem.sv
// -----------------------------------------------------------------------------
// tableau_row_mem
// DEPTH-entry row store, one write port and one registered read port.
// The read register is reset so the replayed row bus starts at all-zero;
// the storage array itself is never cleared.
//
// Ports
//   clk        in   clock
//   rst_new    in   asynchronous active-high reset (read register only)
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write row index
//   i_wr_data  in   row word to store
//   i_rd_en    in   read strobe; read register holds when low
//   i_rd_addr  in   read row index
//   o_rd_data  out  registered read data
// -----------------------------------------------------------------------------
module tableau_row_mem #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 7,
    parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_new,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tableau_row_buffer.sv
// -----------------------------------------------------------------------------
// tableau_row_buffer
// Captures NUM_QUBIT canonical-stage rows, waits for the global-phase unit,
// then replays the rows in order on consecutive cycles.
//
// Ports
//   clk                    in   clock
//   rst_new                in   asynchronous active-high reset
//   literals_in            in   captured row literals (2 bits per qubit)
//   phase_in               in   captured row phase
//   valid_in               in   row strobe
//   valid_P                in   P-basis-ready pulse, held until next readout
//   gp_ready               in   downstream ready; starts readout from WAIT_GP
//   literals_out           out  replayed row literals (holds last row)
//   phase_out              out  replayed row phase (holds last row)
//   valid_out              out  replayed row strobe
//   valid_P_out            out  latched valid_P, aligned with row 0 readout
//   literal_phase_readout  out  high on every readout cycle
//   ld_flag_anticommute    out  one-cycle pulse after the last row is stored
//   overflow_err           out  sticky: row arrived outside CAPTURE
//   gate_count             out  completed readouts, saturating at TOTAL_GATE
// -----------------------------------------------------------------------------
module tableau_row_buffer
    import qcm_pkg::*;
#(
    parameter int unsigned NUM_QUBIT  = 3,
    parameter int unsigned TOTAL_GATE = 30
) (
    input  logic                              clk,
    input  logic                              rst_new,
    input  logic [2*NUM_QUBIT-1:0]            literals_in,
    input  logic                              phase_in,
    input  logic                              valid_in,
    input  logic                              valid_P,
    input  logic                              gp_ready,
    output logic [2*NUM_QUBIT-1:0]            literals_out,
    output logic                              phase_out,
    output logic                              valid_out,
    output logic                              valid_P_out,
    output logic                              literal_phase_readout,
    output logic                              ld_flag_anticommute,
    output logic                              overflow_err,
    output logic [$clog2(TOTAL_GATE+1)-1:0]   gate_count
);

    localparam int unsigned CW = $clog2(NUM_QUBIT + 1);
    localparam int unsigned GW = $clog2(TOTAL_GATE + 1);
    localparam int unsigned RW = 2 * NUM_QUBIT + 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_QUBIT - 1);
    localparam logic [GW-1:0] GATE_MAX = GW'(TOTAL_GATE);

    buf_state_e    r_state;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic [GW-1:0] r_gate_count;
    logic          r_valid_out;
    logic          r_readout;
    logic          r_valid_P_out;
    logic          r_p_latch;
    logic          r_ld_flag;
    logic          r_overflow;

    logic          w_wr_en;
    logic          w_first_rd;
    logic          w_rd_en;
    logic [CW-1:0] w_rd_addr;
    logic          w_last_rd;
    logic [RW-1:0] w_rd_data;

    // Row 0 is read on the same edge that sees gp_ready in WAIT_GP, so the
    // memory's read register doubles as the output register and row 0 is
    // visible one edge after gp_ready. rd_cnt then points at the next row.
    assign w_wr_en    = (r_state == ST_CAPTURE) && valid_in;
    assign w_first_rd = (r_state == ST_WAIT_GP) && gp_ready;
    assign w_rd_en    = w_first_rd || (r_state == ST_READOUT);
    assign w_rd_addr  = w_first_rd ? '0 : r_rd_cnt;
    assign w_last_rd  = w_rd_en && (w_rd_addr == LAST_ROW);

    tableau_row_mem #(
        .DEPTH (NUM_QUBIT),
        .WIDTH (RW),
        .AW    (CW)
    ) u_row_mem (
        .clk       (clk),
        .rst_new   (rst_new),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data ({literals_in, phase_in}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            r_state       <= ST_CAPTURE;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_gate_count  <= '0;
            r_valid_out   <= 1'b0;
            r_readout     <= 1'b0;
            r_valid_P_out <= 1'b0;
            r_p_latch     <= 1'b0;
            r_ld_flag     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_ld_flag     <= 1'b0;
            r_valid_P_out <= 1'b0;
            r_valid_out   <= w_rd_en;
            r_readout     <= w_rd_en;

            if (valid_in && (r_state != ST_CAPTURE)) begin
                r_overflow <= 1'b1;
            end

            // A pulse arriving on the first readout edge itself is forwarded too.
            if (w_first_rd) begin
                r_valid_P_out <= r_p_latch | valid_P;
                r_p_latch     <= 1'b0;
            end else if (valid_P) begin
                r_p_latch <= 1'b1;
            end

            case (r_state)
                ST_CAPTURE: begin
                    if (valid_in) begin
                        if (r_wr_cnt == LAST_ROW) begin
                            r_wr_cnt  <= '0;
                            r_ld_flag <= 1'b1;
                            r_state   <= ST_WAIT_GP;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + CW'(1);
                        end
                    end
                end
                ST_WAIT_GP: begin
                    if (gp_ready) begin
                        r_rd_cnt <= CW'(1);
                        r_state  <= ST_READOUT;
                    end
                end
                ST_READOUT: begin
                    r_rd_cnt <= r_rd_cnt + CW'(1);
                end
                default: begin
                    r_state <= ST_CAPTURE;
                end
            endcase

            // Overrides the case above, which also covers a one-row tableau
            // finishing on the WAIT_GP edge.
            if (w_last_rd) begin
                r_state  <= ST_CAPTURE;
                r_rd_cnt <= '0;
                if (r_gate_count != GATE_MAX) begin
                    r_gate_count <= r_gate_count + GW'(1);
                end
            end
        end
    end

    assign literals_out          = w_rd_data[RW-1:1];
    assign phase_out             = w_rd_data[0];
    assign valid_out             = r_valid_out;
    assign literal_phase_readout = r_readout;
    assign valid_P_out           = r_valid_P_out;
    assign ld_flag_anticommute   = r_ld_flag;
    assign overflow_err          = r_overflow;
    assign gate_count            = r_gate_count;

endmodule
